// File: rtl/spi_link_pkg.sv
// Shared definitions for the SPI link controller: message-type codes,
// the default long-payload opcode, TX state encoding and a length check.
package spi_link_pkg;

   // Message types understood by the SPI slave
   localparam logic [2:0] MSG_1B   = 3'd1;
   localparam logic [2:0] MSG_2B   = 3'd2;
   localparam logic [2:0] MSG_3B   = 3'd3;
   localparam logic [2:0] MSG_6B   = 3'd6;
   localparam logic [2:0] MSG_LONG = 3'd7;

   // Command opcode (cmd[15:12]) announcing a long payload
   localparam logic [3:0] LONG_OP_DEFAULT = 4'hA;

   // Transmit sequencer states
   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_TRIG      = 2'd1,
      ST_WAIT_BUSY = 2'd2,
      ST_WAIT_DONE = 2'd3
   } tx_state_e;

   // A long frame may carry 1..8 bytes
   function automatic logic long_len_ok(input logic [3:0] len);
      return (len != 4'd0) && (len <= 4'd8);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches from last+1 upward (wrapping) and returns
// a one-hot grant for the first active request, or all-zero if none.
module rr_arbiter #(
   parameter int N_REQ = 4,
   parameter int IDX_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] last,
   output logic [N_REQ-1:0] grant
);

   logic             found_s;
   logic [IDX_W-1:0] pos_s;

   // Rotating priority search starting just after the previous winner
   always_comb begin
      grant   = '0;
      found_s = 1'b0;
      pos_s   = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         pos_s = IDX_W'((int'(last) + k) % N_REQ);
         if (req[pos_s] && !found_s) begin
            grant[pos_s] = 1'b1;
            found_s      = 1'b1;
         end else begin
            found_s = found_s;
         end
      end
   end

endmodule

// File: rtl/spi_link_ctrl.sv
// SPI link controller: arbitrates transmit requesters onto a single SPI
// slave (trigger / busy handshake with timeouts) and decodes received
// host commands, including the two-frame long-payload sequence.
module spi_link_ctrl
   import spi_link_pkg::*;
#(
   parameter int         N_REQ   = 4,
   parameter int         BUSY_TO = 16,
   parameter int         XFER_TO = 65535,
   parameter logic [3:0] LONG_OP = LONG_OP_DEFAULT
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic [N_REQ-1:0]      req,
   input  logic [3*N_REQ-1:0]    req_type,
   input  logic [64*N_REQ-1:0]   req_data,
   output logic [N_REQ-1:0]      gnt,
   output logic [N_REQ-1:0]      done,
   output logic                  spi_send_trigger,
   output logic [2:0]            spi_msg_type,
   output logic [63:0]           spi_out_data,
   input  logic                  spi_busy,
   input  logic                  spi_received,
   input  logic [15:0]           spi_rx_short,
   input  logic [63:0]           spi_rx_long,
   output logic                  spi_long_coming,
   output logic [3:0]            spi_byte_count,
   output logic                  cmd_valid,
   output logic [15:0]           cmd_word,
   output logic                  long_valid,
   output logic [63:0]           long_word,
   output logic [1:0]            err
);

   localparam int IDX_W = $clog2(N_REQ);
   localparam int BT_W  = $clog2(BUSY_TO + 1);
   localparam int XT_W  = $clog2(XFER_TO + 1);

   tx_state_e         state_r;
   logic              ready_r;
   logic [N_REQ-1:0]  gnt_r;
   logic [N_REQ-1:0]  done_r;
   logic [IDX_W-1:0]  last_r;
   logic              trig_r;
   logic [2:0]        msg_type_r;
   logic [63:0]       out_data_r;
   logic [BT_W-1:0]   busy_tmr_r;
   logic [XT_W-1:0]   xfer_tmr_r;
   logic              err_to_r;
   logic              err_len_r;
   logic              long_pend_r;
   logic [3:0]        byte_cnt_r;
   logic              cmd_valid_r;
   logic [15:0]       cmd_word_r;
   logic              long_valid_r;
   logic [63:0]       long_word_r;

   logic [N_REQ-1:0]  arb_gnt_s;
   logic [IDX_W-1:0]  win_idx_s;
   logic [2:0]        win_type_s;
   logic [63:0]       win_data_s;
   logic              arb_go_s;

   rr_arbiter #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_arb (
      .req   (req),
      .last  (last_r),
      .grant (arb_gnt_s)
   );

   // Select the winner's index, type and payload from the one-hot grant
   always_comb begin
      win_idx_s  = '0;
      win_type_s = 3'd0;
      win_data_s = 64'd0;
      for (int i = 0; i < N_REQ; i++) begin
         win_idx_s  = win_idx_s  | (arb_gnt_s[i] ? IDX_W'(i)        : '0);
         win_type_s = win_type_s | (arb_gnt_s[i] ? req_type[i*3 +: 3]  : 3'd0);
         win_data_s = win_data_s | (arb_gnt_s[i] ? req_data[i*64 +: 64] : 64'd0);
      end
   end

   // A new grant needs a settled reset, an idle slave and no long frame pending
   always_comb begin
      arb_go_s = 1'b0;
      if (ready_r && !spi_busy && !long_pend_r && (|req)) begin
         arb_go_s = 1'b1;
      end else begin
         arb_go_s = 1'b0;
      end
   end

   // Transmit sequencer: grant, trigger, wait for busy, wait for completion
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_r    <= ST_IDLE;
         ready_r    <= 1'b0;
         gnt_r      <= '0;
         done_r     <= '0;
         last_r     <= IDX_W'(N_REQ - 1);
         trig_r     <= 1'b0;
         msg_type_r <= 3'd0;
         out_data_r <= 64'd0;
         busy_tmr_r <= '0;
         xfer_tmr_r <= '0;
         err_to_r   <= 1'b0;
      end else begin
         ready_r <= 1'b1;
         done_r  <= '0;
         trig_r  <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               busy_tmr_r <= '0;
               xfer_tmr_r <= '0;
               if (arb_go_s) begin
                  gnt_r      <= arb_gnt_s;
                  last_r     <= win_idx_s;
                  msg_type_r <= win_type_s;
                  out_data_r <= win_data_s;
                  trig_r     <= 1'b1;
                  state_r    <= ST_TRIG;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_TRIG: begin
               state_r <= ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
               if (spi_busy) begin
                  busy_tmr_r <= '0;
                  state_r    <= ST_WAIT_DONE;
               end else if (busy_tmr_r == BT_W'(BUSY_TO - 1)) begin
                  err_to_r <= 1'b1;
                  gnt_r    <= '0;
                  state_r  <= ST_IDLE;
               end else begin
                  busy_tmr_r <= busy_tmr_r + BT_W'(1);
               end
            end
            ST_WAIT_DONE: begin
               if (!spi_busy) begin
                  done_r  <= gnt_r;
                  gnt_r   <= '0;
                  state_r <= ST_IDLE;
               end else if (xfer_tmr_r == XT_W'(XFER_TO - 1)) begin
                  err_to_r <= 1'b1;
                  gnt_r    <= '0;
                  state_r  <= ST_IDLE;
               end else begin
                  xfer_tmr_r <= xfer_tmr_r + XT_W'(1);
               end
            end
            default: begin
               gnt_r   <= '0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   // Receive decoder: short commands, long-frame announce and long payload
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         cmd_valid_r  <= 1'b0;
         cmd_word_r   <= 16'd0;
         long_valid_r <= 1'b0;
         long_word_r  <= 64'd0;
         long_pend_r  <= 1'b0;
         byte_cnt_r   <= 4'd0;
         err_len_r    <= 1'b0;
      end else begin
         cmd_valid_r  <= 1'b0;
         long_valid_r <= 1'b0;
         if (spi_received) begin
            if (long_pend_r) begin
               long_valid_r <= 1'b1;
               long_word_r  <= spi_rx_long;
               long_pend_r  <= 1'b0;
            end else begin
               cmd_valid_r <= 1'b1;
               cmd_word_r  <= spi_rx_short;
               long_word_r <= {48'd0, spi_rx_short};
               if (spi_rx_short[15:12] == LONG_OP) begin
                  if (long_len_ok(spi_rx_short[3:0])) begin
                     long_pend_r <= 1'b1;
                     byte_cnt_r  <= spi_rx_short[3:0];
                  end else begin
                     err_len_r <= 1'b1;
                  end
               end else begin
                  long_pend_r <= 1'b0;
               end
            end
         end else begin
            long_pend_r <= long_pend_r;
         end
      end
   end

   assign gnt              = gnt_r;
   assign done             = done_r;
   assign spi_send_trigger = trig_r;
   assign spi_msg_type     = msg_type_r;
   assign spi_out_data     = out_data_r;
   assign spi_long_coming  = long_pend_r;
   assign spi_byte_count   = byte_cnt_r;
   assign cmd_valid        = cmd_valid_r;
   assign cmd_word         = cmd_word_r;
   assign long_valid       = long_valid_r;
   assign long_word        = long_word_r;
   assign err              = {err_len_r, err_to_r};

endmodule

// File: tb/tb_spi_link_ctrl.sv
// Directed self-checking bench for spi_link_ctrl (default parameters).
module tb_spi_link_ctrl;

   localparam logic [63:0] D0 = 64'h1111_2222_3333_4444;
   localparam logic [63:0] D1 = 64'h5555_6666_7777_8888;
   localparam logic [63:0] D2 = 64'h9999_AAAA_BBBB_CCCC;
   localparam logic [63:0] D3 = 64'hDDDD_EEEE_FFFF_0001;

   logic         CLK;
   logic         RST_N;
   logic [3:0]   req;
   logic [11:0]  req_type;
   logic [255:0] req_data;
   logic [3:0]   gnt;
   logic [3:0]   done;
   logic         spi_send_trigger;
   logic [2:0]   spi_msg_type;
   logic [63:0]  spi_out_data;
   logic         spi_busy;
   logic         spi_received;
   logic [15:0]  spi_rx_short;
   logic [63:0]  spi_rx_long;
   logic         spi_long_coming;
   logic [3:0]   spi_byte_count;
   logic         cmd_valid;
   logic [15:0]  cmd_word;
   logic         long_valid;
   logic [63:0]  long_word;
   logic [1:0]   err;

   int n_chk;
   int n_fail;

   spi_link_ctrl dut (
      .CLK              (CLK),
      .RST_N            (RST_N),
      .req              (req),
      .req_type         (req_type),
      .req_data         (req_data),
      .gnt              (gnt),
      .done             (done),
      .spi_send_trigger (spi_send_trigger),
      .spi_msg_type     (spi_msg_type),
      .spi_out_data     (spi_out_data),
      .spi_busy         (spi_busy),
      .spi_received     (spi_received),
      .spi_rx_short     (spi_rx_short),
      .spi_rx_long      (spi_rx_long),
      .spi_long_coming  (spi_long_coming),
      .spi_byte_count   (spi_byte_count),
      .cmd_valid        (cmd_valid),
      .cmd_word         (cmd_word),
      .long_valid       (long_valid),
      .long_word        (long_word),
      .err              (err)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic step(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [2:0] exp_type(input logic [1:0] idx);
      case (idx)
         2'd0:    return 3'd2;
         2'd1:    return 3'd3;
         2'd2:    return 3'd2;
         default: return 3'd7;
      endcase
   endfunction

   function automatic logic [63:0] exp_data(input logic [1:0] idx);
      case (idx)
         2'd0:    return D0;
         2'd1:    return D1;
         2'd2:    return D2;
         default: return D3;
      endcase
   endfunction

   task automatic wait_trig();
      int k = 0;
      while (spi_send_trigger !== 1'b1 && k < 20) begin
         step(1);
         k++;
      end
      chk("trig_seen", {63'd0, spi_send_trigger}, 64'd1);
   endtask

   // Wait for the trigger, check the grant, then play a well-behaved slave
   task automatic serve(input logic [1:0] idx);
      wait_trig();
      chk("gnt_onehot", {60'd0, gnt}, {60'd0, 4'b0001 << idx});
      chk("msg_type", {61'd0, spi_msg_type}, {61'd0, exp_type(idx)});
      chk("out_data", spi_out_data, exp_data(idx));
      chk("done_low_at_trig", {60'd0, done}, 64'd0);
      step(1);
      chk("trig_one_cycle", {63'd0, spi_send_trigger}, 64'd0);
      spi_busy = 1'b1;
      step(2);
      chk("gnt_held_busy", {60'd0, gnt}, {60'd0, 4'b0001 << idx});
      spi_busy = 1'b0;
      step(1);
      chk("done_pulse", {60'd0, done}, {60'd0, 4'b0001 << idx});
      chk("gnt_dropped", {60'd0, gnt}, 64'd0);
   endtask

   initial begin
      n_chk        = 0;
      n_fail       = 0;
      RST_N        = 1'b0;
      req          = 4'b0000;
      req_type     = {3'd7, 3'd2, 3'd3, 3'd2};
      req_data     = {D3, D2, D1, D0};
      spi_busy     = 1'b0;
      spi_received = 1'b0;
      spi_rx_short = 16'd0;
      spi_rx_long  = 64'd0;
      step(2);

      // Reset state
      chk("rst_gnt", {60'd0, gnt}, 64'd0);
      chk("rst_done", {60'd0, done}, 64'd0);
      chk("rst_trig", {63'd0, spi_send_trigger}, 64'd0);
      chk("rst_out_data", spi_out_data, 64'd0);
      chk("rst_err", {62'd0, err}, 64'd0);
      chk("rst_cmd_valid", {63'd0, cmd_valid}, 64'd0);
      chk("rst_long_coming", {63'd0, spi_long_coming}, 64'd0);

      // Two requesters: 0 then 2, first grant two cycles after release
      req   = 4'b0101;
      RST_N = 1'b1;
      step(1);
      chk("gnt_sync_cycle", {60'd0, gnt}, 64'd0);
      step(1);
      chk("first_grant", {60'd0, gnt}, 64'd1);
      serve(2'd0);
      req = 4'b0100;
      serve(2'd2);
      req = 4'b0000;

      // Fresh reset, all four requesting: rotation 0,1,2,3,0,1,2,3
      RST_N = 1'b0;
      step(1);
      req   = 4'b1111;
      RST_N = 1'b1;
      for (int i = 0; i < 8; i++) begin
         serve(2'(i));
      end
      req = 4'b0000;
      step(1);

      // Plain short command also lands in the low bits of long_word
      spi_rx_short = 16'h1234;
      spi_received = 1'b1;
      step(1);
      spi_received = 1'b0;
      chk("short_cmd_valid", {63'd0, cmd_valid}, 64'd1);
      chk("short_cmd_word", {48'd0, cmd_word}, 64'h1234);
      chk("short_long_word", long_word, 64'h0000_0000_0000_1234);
      chk("short_no_long", {63'd0, spi_long_coming}, 64'd0);
      step(1);
      chk("cmd_valid_one_cycle", {63'd0, cmd_valid}, 64'd0);

      // Long announce with 6 bytes
      spi_rx_short = 16'hA006;
      spi_received = 1'b1;
      step(1);
      spi_received = 1'b0;
      chk("ann_cmd_valid", {63'd0, cmd_valid}, 64'd1);
      chk("ann_cmd_word", {48'd0, cmd_word}, 64'hA006);
      chk("ann_long_coming", {63'd0, spi_long_coming}, 64'd1);
      chk("ann_byte_count", {60'd0, spi_byte_count}, 64'd6);

      // No grant while the long frame is pending
      req = 4'b0001;
      step(3);
      chk("pend_no_gnt", {60'd0, gnt}, 64'd0);
      chk("pend_no_trig", {63'd0, spi_send_trigger}, 64'd0);

      // Long payload completes the sequence
      spi_rx_long  = 64'h0123_4567_89AB_CDEF;
      spi_received = 1'b1;
      step(1);
      spi_received = 1'b0;
      chk("long_valid", {63'd0, long_valid}, 64'd1);
      chk("long_word", long_word, 64'h0123_4567_89AB_CDEF);
      chk("long_coming_clr", {63'd0, spi_long_coming}, 64'd0);
      chk("long_no_cmd_valid", {63'd0, cmd_valid}, 64'd0);
      step(1);
      chk("long_valid_one_cycle", {63'd0, long_valid}, 64'd0);
      chk("gnt_after_long", {60'd0, gnt}, 64'd1);
      serve(2'd0);
      req = 4'b0000;
      step(1);

      // Bad long length
      spi_rx_short = 16'hA000;
      spi_received = 1'b1;
      step(1);
      spi_received = 1'b0;
      chk("badlen_cmd_valid", {63'd0, cmd_valid}, 64'd1);
      chk("badlen_err", {62'd0, err}, 64'd2);
      chk("badlen_no_long", {63'd0, spi_long_coming}, 64'd0);

      // Slave never raises busy: timeout 17 cycles after the trigger
      req = 4'b0010;
      wait_trig();
      chk("to_gnt", {60'd0, gnt}, 64'd2);
      for (int c = 1; c <= 16; c++) begin
         step(1);
         chk("to_no_done", {60'd0, done}, 64'd0);
      end
      chk("to_err_not_yet", {62'd0, err}, 64'd2);
      step(1);
      chk("to_err_set", {62'd0, err}, 64'd3);
      chk("to_gnt_drop", {60'd0, gnt}, 64'd0);
      chk("to_no_done_end", {60'd0, done}, 64'd0);
      step(1);
      chk("to_back_idle_trig", {63'd0, spi_send_trigger}, 64'd1);
      chk("to_regrant", {60'd0, gnt}, 64'd2);
      step(1);
      spi_busy = 1'b1;
      step(1);
      spi_busy = 1'b0;
      step(1);
      chk("to_retry_done", {60'd0, done}, 64'd2);
      req = 4'b0000;
      step(1);

      // Reset in the middle of a send
      req = 4'b0001;
      wait_trig();
      step(1);
      spi_busy = 1'b1;
      step(2);
      chk("mid_gnt", {60'd0, gnt}, 64'd1);
      RST_N = 1'b0;
      #1;
      chk("arst_gnt", {60'd0, gnt}, 64'd0);
      chk("arst_trig", {63'd0, spi_send_trigger}, 64'd0);
      chk("arst_err", {62'd0, err}, 64'd0);
      chk("arst_out_data", spi_out_data, 64'd0);
      chk("arst_msg_type", {61'd0, spi_msg_type}, 64'd0);
      chk("arst_cmd_word", {48'd0, cmd_word}, 64'd0);
      chk("arst_long_word", long_word, 64'd0);
      req      = 4'b0000;
      spi_busy = 1'b0;
      step(1);
      RST_N = 1'b1;
      for (int c = 0; c < 4; c++) begin
         step(1);
         chk("post_rst_no_done", {60'd0, done}, 64'd0);
         chk("post_rst_no_gnt", {60'd0, gnt}, 64'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/spi_link_ctrl.md
SPI_LINK_CTRL -- requirements
Module: spi_link_ctrl

Interface
REQ-001 Parameter N_REQ, default 4: number of transmit requesters (2..8).
REQ-002 Parameter BUSY_TO, default 16: max cycles from trigger to spi_busy high.
REQ-003 Parameter XFER_TO, default 65535: max cycles spi_busy may stay high for one send.
REQ-004 Parameter LONG_OP, default 4'hA: command opcode (cmd[15:12]) that announces a long payload.
REQ-005 CLK  in  1  single clock; every register is clocked on its rising edge.
REQ-006 RST_N  in  1  asynchronous, active-low reset.
REQ-007 req  in  N_REQ  level request per requester; held until the matching done.
REQ-008 req_type  in  3*N_REQ  message type per requester: 1, 2, 3 or 6 bytes, or 7 = long.
REQ-009 req_data  in  64*N_REQ  payload per requester; the MSB-aligned bit is sent first.
REQ-010 gnt  out  N_REQ  one-hot; high from grant until done.
REQ-011 done  out  N_REQ  one-cycle pulse at send completion.
REQ-012 spi_send_trigger  out  1  one-cycle send strobe to the SPI slave.
REQ-013 spi_msg_type  out  3  type to the slave; valid while spi_send_trigger is high.
REQ-014 spi_out_data  out  64  payload to the slave; held for the whole send.
REQ-015 spi_busy  in  1  slave busy.
REQ-016 spi_received  in  1  slave receive-done pulse.
REQ-017 spi_rx_short  in  16  last short word (received_data[15:0]).
REQ-018 spi_rx_long  in  64  long payload.
REQ-019 spi_long_coming  out  1  tells the slave the next frame is long.
REQ-020 spi_byte_count  out  4  long frame length in bytes.
REQ-021 cmd_valid  out  1  one-cycle pulse; cmd_word is valid with it.
REQ-022 cmd_word  out  16  decoded host command.
REQ-023 long_valid  out  1  one-cycle pulse; long_word is valid with it.
REQ-024 long_word  out  64  long payload.
REQ-025 err  out  2  sticky error bits: [0] timeout, [1] bad length; cleared only by reset.

Function
REQ-026 TX FSM states and transitions: IDLE -> TRIG -> WAIT_BUSY -> WAIT_DONE -> IDLE.
REQ-027 IDLE arbitration: entered only when spi_busy=0 and long_pend=0 and any req is high.
REQ-028 Arbitration is round-robin, starting from last_grant+1 (last_grant resets to N_REQ-1, so requester 0 wins first).
REQ-029 On grant: latch the winner's type and data into spi_msg_type and spi_out_data, assert gnt, go to TRIG.
REQ-030 TRIG: spi_send_trigger=1 for exactly one cycle; next state WAIT_BUSY.
REQ-031 WAIT_BUSY: on spi_busy=1, go to WAIT_DONE; if BUSY_TO cycles pass without it, set err[0] and finish.
REQ-032 WAIT_DONE: on spi_busy falling to 0, pulse done for the granted requester, drop gnt, go to IDLE.
REQ-033 WAIT_DONE timeout: if spi_busy stays high for XFER_TO cycles, set err[0] and finish without done.
REQ-034 Finishing in IDLE takes one cycle, so the minimum spacing between two triggers is 4 cycles.
REQ-035 RX: spi_received with long_pend=0 pulses cmd_valid one cycle later, with cmd_word=spi_rx_short.
REQ-036 RX long announce: if cmd[15:12]==LONG_OP and 1<=cmd[3:0]<=8, set long_pend=1, spi_long_coming=1 and spi_byte_count=cmd[3:0].
REQ-037 RX bad length: LONG_OP with cmd[3:0]==0 or >8 sets err[1]; long_pend stays 0.
REQ-038 RX long completion: spi_received with long_pend=1 pulses long_valid with long_word=spi_rx_long, then clears long_pend and spi_long_coming.
REQ-039 A short frame's payload is also reported as long_word, in the low bits.
REQ-040 While long_pend=1 no new grant is issued; a send already in flight completes normally.
REQ-041 If spi_received and a grant decision occur in the same cycle, both are processed.
REQ-042 If req drops while granted, the send still completes and done still pulses.

Reset
REQ-043 RST_N low asynchronously forces: FSM to IDLE; gnt, done, spi_send_trigger, cmd_valid and long_valid to 0.
REQ-044 RST_N low also clears spi_msg_type, spi_out_data, cmd_word, long_word, spi_byte_count, spi_long_coming, long_pend, err and both timers to 0.
REQ-045 Reset mid-send abandons the send; no done is issued after release.
REQ-046 The first grant after reset release may occur 2 cycles after release (1 sync cycle + arbitration).

Structure
REQ-047 A shared package spi_link_pkg holds the message-type constants (1, 2, 3, 6, 7), LONG_OP, and the TX state encoding.
REQ-048 Round-robin arbitration is one sub-module, rr_arbiter (req, last -> one-hot grant); everything else is in spi_link_ctrl.

Verification
REQ-049 req=4'b0101, both type 2 -> gnt 0001, one trigger with msg_type=2, done[0] after busy falls, then gnt 0100.
REQ-050 All 4 req held for 8 sends -> grant order 0,1,2,3,0,1,2,3, every done one cycle wide.
REQ-051 spi_received with rx_short=16'hA006, then with rx_long=64'h0123456789ABCDEF -> spi_long_coming=1, count=6, long_valid with that value, long_coming=0.
REQ-052 rx_short=16'hA000 -> err[1]=1, cmd_valid pulses, spi_long_coming stays 0.
REQ-053 Slave never raises busy -> err[0]=1 17 cycles after trigger, no done, FSM back in IDLE.
REQ-054 RST_N low during WAIT_DONE -> all outputs 0 within the same cycle, no done after release.
